alu_bitserial_seq: RTL and testbench

//   Word-level initiator for the existing 1-bit ALU slice. Accepts a WIDTH-bit operation over a start/ready handshake.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_bitserial_seq_if.sv | 43 ++++
 rtl/alu_bitserial_seq.sv | 127 ++++++++++++
 tb/tb_alu_bitserial_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Op codes, slice selectors, FSM states and op decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SET = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SLT_SET = 3'd2,
    ST_DONE    = 3'd3
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // SUB and SLT run as a + ~b + 1: invert B and seed carry-in with 1.
  function automatic logic op_inver(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic op_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic [2:0] op_sel(input logic [3:0] op);
    case (op)
      OP_AND:  return SEL_AND;
      OP_OR:   return SEL_OR;
      OP_XOR:  return SEL_XOR;
      default: return SEL_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bitserial_seq_if.sv
// ============================================================================
// Module   : alu_bitserial_seq_if
// Brief    : Request handshake, result and 1-bit slice signals of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_bitserial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             ready_o;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             slice_a_o;
  logic             slice_b_o;
  logic             slice_c_o;
  logic [3:0]       slice_sel_o;
  logic             slice_inver_o;
  logic             slice_set_o;
  logic             slice_res_i;
  logic             slice_c_i;
  logic [WIDTH-1:0] res_o;
  logic             cout_o;
  logic             zero_o;
  logic             err_o;
  logic             done_o;

  modport slave (
    input  start_i, op_i, a_i, b_i, slice_res_i, slice_c_i,
    output ready_o, slice_a_o, slice_b_o, slice_c_o, slice_sel_o, slice_inver_o,
           slice_set_o, res_o, cout_o, zero_o, err_o, done_o
  );

  modport master (
    output start_i, op_i, a_i, b_i, slice_res_i, slice_c_i,
    input  ready_o, slice_a_o, slice_b_o, slice_c_o, slice_sel_o, slice_inver_o,
           slice_set_o, res_o, cout_o, zero_o, err_o, done_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_bitserial_seq.sv
// ============================================================================
// Module   : alu_bitserial_seq
// Brief    : Drives an external 1-bit ALU slice LSB-first to run a WIDTH-bit op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_bitserial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  alu_bitserial_seq_if.slave  bus
);

  localparam int             CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic             r_carry;
  logic             r_slt;
  logic             r_cout;
  logic             r_err;
  logic             r_done;

  logic             w_run;
  logic             w_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
      r_slt   <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_a_sh  <= bus.a_i;
            r_b_sh  <= bus.b_i;
            r_op    <= bus.op_i;
            r_cnt   <= '0;
            r_carry <= op_inver(bus.op_i);
            r_slt   <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            if (op_legal(bus.op_i)) begin
              r_err   <= 1'b0;
              r_state <= ST_RUN;
            end else begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          r_res   <= {bus.slice_res_i, r_res[WIDTH-1:1]};
          r_carry <= bus.slice_c_i;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            if (op_arith(r_op)) begin
              r_cout <= bus.slice_c_i;
            end
            // Less-than is the MSB difference bit corrected for signed overflow.
            if (r_op == OP_SLT) begin
              r_slt   <= bus.slice_res_i ^ r_carry ^ bus.slice_c_i;
              r_state <= ST_SLT_SET;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_SLT_SET: begin
          r_res   <= {{(WIDTH-1){1'b0}}, bus.slice_res_i};
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_run = (r_state == ST_RUN);
  assign w_set = (r_state == ST_SLT_SET);

  assign bus.slice_a_o     = w_run & r_a_sh[0];
  assign bus.slice_b_o     = w_run & r_b_sh[0];
  assign bus.slice_c_o     = w_run & r_carry;
  assign bus.slice_inver_o = w_run & op_inver(r_op);
  assign bus.slice_set_o   = w_set & r_slt;
  assign bus.slice_sel_o   = w_run ? {1'b0, op_sel(r_op)} :
                             w_set ? {1'b0, SEL_SET}      : 4'b0000;

  assign bus.ready_o = (r_state == ST_IDLE);
  assign bus.res_o   = r_res;
  assign bus.zero_o  = (r_res == '0);
  assign bus.cout_o  = r_cout;
  assign bus.err_o   = r_err;
  assign bus.done_o  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_bitserial_seq.sv
// ============================================================================
// Module   : tb_alu_bitserial_seq
// Brief    : Bench for alu_bitserial_seq (WIDTH=8) with a behavioural 1-bit slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_bitserial_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  alu_bitserial_seq_if #(.WIDTH(W)) bus ();

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Combinational 1-bit ALU slice: b optionally inverted, full-adder carry.
  logic sl_b;
  assign sl_b = bus.slice_b_o ^ bus.slice_inver_o;
  assign bus.slice_c_i = (bus.slice_a_o & sl_b) | (bus.slice_a_o & bus.slice_c_o) |
                         (sl_b & bus.slice_c_o);
  always_comb begin
    bus.slice_res_i = 1'b0;
    case (bus.slice_sel_o)
      4'b0000: bus.slice_res_i = bus.slice_a_o & sl_b;
      4'b0001: bus.slice_res_i = bus.slice_a_o | sl_b;
      4'b0010: bus.slice_res_i = bus.slice_a_o ^ sl_b ^ bus.slice_c_o;
      4'b0011: bus.slice_res_i = bus.slice_set_o;
      4'b0100: bus.slice_res_i = bus.slice_a_o ^ sl_b;
      default: bus.slice_res_i = 1'b0;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Word-level expectation of one operation.
  function automatic void model_op(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] r,
                                   output bit c, output bit e, output int lat);
    logic [W:0] diff;
    logic [W:0] sum;
    diff = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    sum  = {1'b0, a} + {1'b0, b};
    r = '0; c = 1'b0; e = 1'b0; lat = W + 1;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_ADD: begin r = sum[W-1:0];  c = sum[W];  end
      OP_SUB: begin r = diff[W-1:0]; c = diff[W]; end
      OP_SLT: begin
        r   = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        c   = diff[W];
        lat = W + 2;
      end
      default: begin e = 1'b1; lat = 1; end
    endcase
  endfunction

  // Model state: busy from accept until the edge after done.
  bit          m_busy = 1'b0;
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [W-1:0] m_res = '0;
  bit          m_cout = 1'b0;
  bit          m_err  = 1'b0;
  logic [W-1:0] p_res;
  bit          p_cout;
  bit          p_err;
  int          p_lat;

  task automatic publish();
    m_res  = p_res;
    m_cout = p_cout;
    m_err  = p_err;
    m_done = 1'b1;
    m_run  = 1'b0;
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 1'b0; m_run = 1'b0; m_done = 1'b0;
      m_res  = '0;   m_cout = 1'b0; m_err = 1'b0;
    end else if (!m_busy) begin
      if (bus.start_i) begin
        model_op(bus.op_i, bus.a_i, bus.b_i, p_res, p_cout, p_err, p_lat);
        m_busy = 1'b1; m_run = 1'b1;
        m_res  = '0;   m_cout = 1'b0; m_err = 1'b0;
        m_left = p_lat - 1;
        if (m_left == 0) publish();
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) publish();
    end
  end

  always @(negedge clk_i) begin
    chk("ready", 32'(bus.ready_o), 32'(!m_busy));
    chk("done", 32'(bus.done_o), 32'(m_done));
    if (!m_run) begin
      chk("res", 32'(bus.res_o), 32'(m_res));
      chk("cout", 32'(bus.cout_o), 32'(m_cout));
      chk("err", 32'(bus.err_o), 32'(m_err));
      chk("zero", 32'(bus.zero_o), 32'(m_res == '0));
      chk("slice_idle", 32'({bus.slice_a_o, bus.slice_b_o, bus.slice_c_o, bus.slice_sel_o,
                             bus.slice_inver_o, bus.slice_set_o}), 32'(0));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("idle_timeout", 32'(m_busy), 32'(0));
  endtask

  // Directed op with literal expectations; optional start_i poke while busy.
  task automatic run_dir(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input bit ec,
                         input bit ee, input int el, input int poke);
    int lat;
    bit seen;
    wait_idle();
    bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0; bus.op_i = 4'($urandom); bus.a_i = W'($urandom); bus.b_i = W'($urandom);
    lat = 1; seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (bus.done_o) begin
        seen = 1'b1;
      end else begin
        if (lat == poke) begin
          bus.start_i = 1'b1; bus.op_i = OP_SUB; bus.a_i = ~a; bus.b_i = ~b;
        end
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
        lat++;
      end
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'(1));
    chk({nm, "_lat"}, 32'(lat), 32'(el));
    chk({nm, "_res"}, 32'(bus.res_o), 32'(er));
    chk({nm, "_cout"}, 32'(bus.cout_o), 32'(ec));
    chk({nm, "_err"}, 32'(bus.err_o), 32'(ee));
    chk({nm, "_zero"}, 32'(bus.zero_o), 32'(er == '0));
  endtask

  logic [3:0]   ops   [0:5] = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT};
  logic [W-1:0] edges [0:3] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

  initial begin
    bus.start_i = 1'b0; bus.op_i = '0; bus.a_i = '0; bus.b_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(bus.ready_o), 32'(1));
    chk("rst_zero", 32'(bus.zero_o), 32'(1));
    rst_ni = 1'b1;

    run_dir("add_7f_01",  OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 9,  0);
    run_dir("sub_eq",     OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 9,  0);
    run_dir("sub_borrow", OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 9,  0);
    run_dir("slt_ovf",    OP_SLT, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0, 10, 0);
    run_dir("slt_no",     OP_SLT, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 10, 0);
    run_dir("and",        OP_AND, 8'hCA, 8'h5C, 8'h48, 1'b0, 1'b0, 9,  0);
    run_dir("or",         OP_OR,  8'hCA, 8'h5C, 8'hDE, 1'b0, 1'b0, 9,  0);
    run_dir("xor",        OP_XOR, 8'hCA, 8'h5C, 8'h96, 1'b0, 1'b0, 9,  0);
    run_dir("illegal",    4'b0101, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1, 0);
    run_dir("add_clr",    OP_ADD, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 9,  0);
    run_dir("add_wrap",   OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 9,  0);
    run_dir("sub_0_1",    OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 9,  0);

    // Reset part-way through an ADD abandons it.
    wait_idle();
    bus.start_i = 1'b1; bus.op_i = OP_ADD; bus.a_i = 8'h55; bus.b_i = 8'h66;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready_o), 32'(1));
    chk("mid_rst_res", 32'(bus.res_o), 32'(0));
    chk("mid_rst_done", 32'(bus.done_o), 32'(0));
    chk("mid_rst_cout", 32'(bus.cout_o), 32'(0));
    chk("mid_rst_zero", 32'(bus.zero_o), 32'(1));
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (12) @(posedge clk_i);
    #1;
    run_dir("add_poke", OP_ADD, 8'h3C, 8'h4B, 8'h87, 1'b0, 1'b0, 9, 3);

    for (int i = 0; i < 2000; i++) begin
      int k;
      k = $urandom_range(0, 7);
      bus.start_i = ($urandom_range(0, 3) != 0);
      bus.op_i    = (k < 6) ? ops[k] : 4'($urandom);
      bus.a_i     = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      bus.b_i     = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      if (i == 1000) rst_ni = 1'b0;
      if (i == 1002) rst_ni = 1'b1;
      @(posedge clk_i); #1;
    end
    bus.start_i = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
